vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Source end of the VGA pixel interface: drives VGA_CLK, VGA_BLANK_N and the raster
//  position (DrawX/DrawY) consumed by the sprite/background lookups and color mapper.
//  It also drives the VGA_HS/VGA_VS/VGA_SYNC_N pins of the video DAC.
//  Syncs are delayed by SYNC_DELAY pixels to match the mapper's registered RGB output.
//  frame_start is the per-frame tick for game logic (player/enemy/attack motion).
// PARAMETERS
//  H_VISIBLE   640  visible pixels per line
//  H_FRONT     16   horizontal front porch, pixels
//  H_SYNC      96   horizontal sync width, pixels
//  H_BACK      48   horizontal back porch, pixels
//  V_VISIBLE   480  visible lines per frame
//  V_FRONT     10   vertical front porch, lines
//  V_SYNC      2    vertical sync width, lines
//  V_BACK      33   vertical back porch, lines
//  SYNC_DELAY  1    pixel ticks of delay on VGA_HS/VGA_VS vs DrawX/DrawY (0..4)
// PORTS
//  Clk          in   1   50 MHz system clock
//  Reset_n      in   1   asynchronous, active-low reset
//  VGA_CLK      out  1   pixel clock = Clk/2, registered toggle
//  VGA_BLANK_N  out  1   1 = current (DrawX,DrawY) is visible
//  VGA_SYNC_N   out  1   tied 0 (no sync-on-green)
//  VGA_HS       out  1   horizontal sync, active low, delayed SYNC_DELAY pixels
//  VGA_VS       out  1   vertical sync, active low, delayed SYNC_DELAY pixels
//  DrawX        out  10  current pixel column, 0..H_TOTAL-1
//  DrawY        out  10  current line, 0..V_TOTAL-1
//  frame_start  out  1   1-Clk pulse when the raster enters (0,0)
// BEHAVIOUR
//  - H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
//    Both must be <= 1024; this is enforced by an elaboration-time check.
//  - Reset (async assert, sync release):
//    VGA_CLK=0, DrawX=0, DrawY=0, VGA_BLANK_N=1, VGA_HS=1, VGA_VS=1, frame_start=0.
//    The sync delay pipe is filled with 1s.
//  - VGA_CLK toggles on every Clk edge.
//  - Pixel tick = a Clk edge at which VGA_CLK is currently 1.
//    Position outputs therefore change on falling VGA_CLK and are stable at rising VGA_CLK.
//    Each pixel lasts exactly 2 Clk cycles.
//  - On a pixel tick:
//    DrawX <= (DrawX==H_TOTAL-1) ? 0 : DrawX+1.
//    DrawY advances only when DrawX wraps: DrawY <= (DrawY==V_TOTAL-1) ? 0 : DrawY+1.
//  - VGA_BLANK_N is registered from the next-state counters, so it is aligned with
//    DrawX/DrawY: 1 iff DrawX<H_VISIBLE && DrawY<V_VISIBLE.
//  - Raw hsync is low iff next DrawX is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]
//    (656..751 with defaults).
//  - Raw vsync is low iff next DrawY is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1]
//    (490..491 with defaults). Raw vsync changes at the same tick as DrawY.
//  - Raw syncs pass through a SYNC_DELAY-stage shift register that advances only on
//    pixel ticks. With SYNC_DELAY=0, VGA_HS/VGA_VS are aligned with DrawX/DrawY.
//  - frame_start is 1 for exactly the Clk cycle after the tick that moves (H_TOTAL-1,
//    V_TOTAL-1) to (0,0). It is not asserted on reset release.
//  - Reset asserted mid-line or mid-frame: all outputs return to their reset values
//    immediately. The first frame after release starts at (0,0) without a frame_start pulse.
// TESTING
//  1 Release reset, run 2000 Clk -> VGA_CLK toggles every Clk; DrawX steps 0,1,2..
//    every 2 Clk; after 799 DrawX=0 and DrawY=1.
//  2 Defaults, one line -> VGA_HS low for exactly 96 pixels (192 Clk).
//    The first low pixel has DrawX=657 (SYNC_DELAY=1); high again at DrawX=753.
//  3 One full frame -> VGA_VS low for exactly 1600 pixels (2 lines), starting one pixel
//    after DrawY becomes 490.
//  4 One frame -> VGA_BLANK_N high on exactly 307200 pixels, all with DrawX<640 and
//    DrawY<480; low at (640,0) and (0,480).
//  5 Three frames -> frame_start pulses are spaced exactly 840000 Clk apart, each one Clk
//    wide; no pulse at reset release.
//  6 Assert Reset_n=0 at DrawX=300,DrawY=200 between Clk edges -> all outputs take reset
//    values without a Clk edge. After release, (0,0) -> (1,0) follows 2 Clk later.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: pixel clock, raster position, blanking and delayed syncs.
// The pixel clock is Clk/2; all raster state advances on the Clk edge where VGA_CLK is high.
module vga_timing_gen #(
   parameter int H_VISIBLE  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter int SYNC_DELAY = 1
) (
   input  logic       Clk,
   input  logic       Reset_n,
   output logic       VGA_CLK,
   output logic       VGA_BLANK_N,
   output logic       VGA_SYNC_N,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       frame_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   generate
      if (H_TOTAL > 1024 || V_TOTAL > 1024 || SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_bad_params
         $error("vga_timing_gen: totals must be <= 1024 and SYNC_DELAY in 0..4");
      end
   endgenerate

   // 11-bit bounds so an exclusive end of 1024 does not wrap to zero
   localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS      = 11'(H_VISIBLE);
   localparam logic [10:0] V_VIS      = 11'(V_VISIBLE);
   localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

   logic       r_vga_clk;
   logic [9:0] r_x;
   logic [9:0] r_y;
   logic       r_blank_n;
   logic       r_hs_raw;
   logic       r_vs_raw;
   logic       r_frame_start;

   logic        w_tick;
   logic        w_x_wrap;
   logic        w_y_wrap;
   logic [9:0]  w_x_next;
   logic [9:0]  w_y_next;
   logic [10:0] w_x_next_ext;
   logic [10:0] w_y_next_ext;
   logic        w_hs_low;
   logic        w_vs_low;

   assign w_tick       = r_vga_clk;
   assign w_x_wrap     = (r_x == H_LAST);
   assign w_y_wrap     = (r_y == V_LAST);
   assign w_x_next     = w_x_wrap ? 10'd0 : r_x + 10'd1;
   assign w_y_next     = w_x_wrap ? (w_y_wrap ? 10'd0 : r_y + 10'd1) : r_y;
   assign w_x_next_ext = {1'b0, w_x_next};
   assign w_y_next_ext = {1'b0, w_y_next};
   assign w_hs_low     = (w_x_next_ext >= H_SYNC_BEG) && (w_x_next_ext < H_SYNC_END);
   assign w_vs_low     = (w_y_next_ext >= V_SYNC_BEG) && (w_y_next_ext < V_SYNC_END);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_vga_clk     <= 1'b0;
         r_x           <= 10'd0;
         r_y           <= 10'd0;
         r_blank_n     <= 1'b1;
         r_hs_raw      <= 1'b1;
         r_vs_raw      <= 1'b1;
         r_frame_start <= 1'b0;
      end else begin
         r_vga_clk     <= ~r_vga_clk;
         r_frame_start <= w_tick && w_x_wrap && w_y_wrap;
         if (w_tick) begin
            r_x       <= w_x_next;
            r_y       <= w_y_next;
            r_blank_n <= (w_x_next_ext < H_VIS) && (w_y_next_ext < V_VIS);
            r_hs_raw  <= ~w_hs_low;
            r_vs_raw  <= ~w_vs_low;
         end
      end
   end

   // Sync delay pipe matches the color mapper's registered RGB latency
   generate
      if (SYNC_DELAY == 0) begin : g_no_delay
         assign VGA_HS = r_hs_raw;
         assign VGA_VS = r_vs_raw;
      end else begin : g_delay
         logic [SYNC_DELAY-1:0] r_hs_pipe;
         logic [SYNC_DELAY-1:0] r_vs_pipe;
         logic [SYNC_DELAY:0]   w_hs_chain;
         logic [SYNC_DELAY:0]   w_vs_chain;

         assign w_hs_chain = {r_hs_pipe, r_hs_raw};
         assign w_vs_chain = {r_vs_pipe, r_vs_raw};

         always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
               r_hs_pipe <= '1;
               r_vs_pipe <= '1;
            end else if (w_tick) begin
               r_hs_pipe <= w_hs_chain[SYNC_DELAY-1:0];
               r_vs_pipe <= w_vs_chain[SYNC_DELAY-1:0];
            end
         end

         assign VGA_HS = r_hs_pipe[SYNC_DELAY-1];
         assign VGA_VS = r_vs_pipe[SYNC_DELAY-1];
      end
   endgenerate

   assign VGA_CLK     = r_vga_clk;
   assign VGA_BLANK_N = r_blank_n;
   assign VGA_SYNC_N  = 1'b0;
   assign DrawX       = r_x;
   assign DrawY       = r_y;
   assign frame_start = r_frame_start;

endmodule
